// File: rtl/count_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// count_seq_pkg
//   Shared definitions for the two-phase count sequencer.
//   - state_t : 2-bit FSM encoding (IDLE=0, PHASE_A=1, PHASE_B=2, DONE=3)
//   - DEF_*   : default counter width, phase terminal values and prescale ratio
// ----------------------------------------------------------------------------
package count_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_A    = 2'd1,
    ST_B    = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_LIMIT_A = 10;
  localparam int DEF_LIMIT_B = 15;
  localparam int DEF_DIV     = 2;

endpackage

// File: rtl/count_sequencer_tick_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler
//   Clock-enable generator for phase B: asserts tick on one clock out of every
//   DIV clocks while run is high. DIV=1 gives a tick on every running cycle.
// Ports
//   clk  in  1  single clock
//   rst  in  1  asynchronous active-low reset
//   clr  in  1  synchronous clear of the prescale count (outranks run)
//   run  in  1  count while high, hold while low
//   tick out 1  high when the prescale count sits at DIV-1 and run is high
// ----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int            PW   = $clog2(DIV) + 1;
  localparam logic [PW-1:0] TERM = PW'(DIV - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] pre_r;
  logic [PW-1:0] pre_nx_s;

  // tick is qualified by run so a stale count cannot fire outside phase B
  always_comb begin
    tick = run && (pre_r == TERM);
  end

  // next prescale count: clear, wrap at DIV-1, or advance
  always_comb begin
    pre_nx_s = pre_r;
    if (clr) begin
      pre_nx_s = '0;
    end else if (run) begin
      if (pre_r == TERM) begin
        pre_nx_s = '0;
      end else begin
        pre_nx_s = pre_r + ONE;
      end
    end else begin
      pre_nx_s = pre_r;
    end
  end

  // prescale count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_r <= '0;
    end else begin
      pre_r <= pre_nx_s;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// ----------------------------------------------------------------------------
// count_sequencer
//   Two-phase count sequencer with start/busy/finish handshake. Phase A counts
//   0..LIMIT_A at full rate while enable is high; phase B counts 0..LIMIT_B on a
//   prescaled tick (one per DIV clocks). Single clock, clock-enable style.
// Ports
//   clk    in  1      single clock, all state on posedge
//   rst    in  1      asynchronous active-low reset
//   start  in  1      begin a run (honoured in IDLE and DONE only)
//   enable in  1      phase-A count enable
//   abort  in  1      synchronous return to IDLE, outranks everything else
//   out    out WIDTH  current phase count, 0 in IDLE and DONE
//   phase  out 1      1 while in phase B
//   busy   out 1      1 while in phase A or phase B
//   finish out 1      sticky completion flag, cleared by start or abort
// All outputs are flops loaded from the next-state values, so they carry the
// same cycle timing as a decode of the state register with no input-to-output
// combinational path.
// ----------------------------------------------------------------------------
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LIMIT_A = DEF_LIMIT_A,
  parameter int LIMIT_B = DEF_LIMIT_B,
  parameter int DIV     = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] out,
  output logic             phase,
  output logic             busy,
  output logic             finish
);

  localparam logic [WIDTH-1:0] TERM_A = WIDTH'(LIMIT_A);
  localparam logic [WIDTH-1:0] TERM_B = WIDTH'(LIMIT_B);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

  state_t           state_r;
  state_t           state_nx_s;
  logic [WIDTH-1:0] cnt_a_r;
  logic [WIDTH-1:0] cnt_a_nx_s;
  logic [WIDTH-1:0] cnt_b_r;
  logic [WIDTH-1:0] cnt_b_nx_s;
  logic             finish_r;
  logic             finish_nx_s;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] out_nx_s;
  logic             phase_r;
  logic             phase_nx_s;
  logic             busy_r;
  logic             busy_nx_s;
  logic             presc_clr_s;
  logic             presc_run_s;
  logic             tick_s;

  // prescaler runs only in phase B; its own clear outranks run
  always_comb begin
    presc_run_s = (state_r == ST_B);
  end

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr_s),
    .run  (presc_run_s),
    .tick (tick_s)
  );

  // FSM next-state and counter next values; abort has top priority
  always_comb begin
    state_nx_s  = state_r;
    cnt_a_nx_s  = cnt_a_r;
    cnt_b_nx_s  = cnt_b_r;
    finish_nx_s = finish_r;
    presc_clr_s = 1'b0;
    if (abort) begin
      state_nx_s  = ST_IDLE;
      cnt_a_nx_s  = '0;
      cnt_b_nx_s  = '0;
      finish_nx_s = 1'b0;
      presc_clr_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_nx_s  = ST_A;
            cnt_a_nx_s  = '0;
            cnt_b_nx_s  = '0;
            finish_nx_s = 1'b0;
          end else begin
            state_nx_s  = state_r;
          end
        end
        ST_A: begin
          if (enable) begin
            if (cnt_a_r == TERM_A) begin
              // phase B starts from a clean prescale count
              state_nx_s  = ST_B;
              cnt_a_nx_s  = '0;
              cnt_b_nx_s  = '0;
              presc_clr_s = 1'b1;
            end else begin
              cnt_a_nx_s  = cnt_a_r + ONE_W;
            end
          end else begin
            cnt_a_nx_s = cnt_a_r;
          end
        end
        ST_B: begin
          if (tick_s) begin
            if (cnt_b_r == TERM_B) begin
              state_nx_s  = ST_DONE;
              cnt_b_nx_s  = '0;
              finish_nx_s = 1'b1;
            end else begin
              cnt_b_nx_s  = cnt_b_r + ONE_W;
            end
          end else begin
            cnt_b_nx_s = cnt_b_r;
          end
        end
        default: begin
          state_nx_s  = ST_IDLE;
          cnt_a_nx_s  = '0;
          cnt_b_nx_s  = '0;
          finish_nx_s = 1'b0;
          presc_clr_s = 1'b1;
        end
      endcase
    end
  end

  // output decode from the next state so the output flops track the state register
  always_comb begin
    out_nx_s   = '0;
    phase_nx_s = 1'b0;
    busy_nx_s  = 1'b0;
    case (state_nx_s)
      ST_A: begin
        out_nx_s  = cnt_a_nx_s;
        busy_nx_s = 1'b1;
      end
      ST_B: begin
        out_nx_s   = cnt_b_nx_s;
        phase_nx_s = 1'b1;
        busy_nx_s  = 1'b1;
      end
      default: begin
        out_nx_s   = '0;
        phase_nx_s = 1'b0;
        busy_nx_s  = 1'b0;
      end
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      cnt_a_r  <= '0;
      cnt_b_r  <= '0;
      finish_r <= 1'b0;
      out_r    <= '0;
      phase_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      cnt_a_r  <= cnt_a_nx_s;
      cnt_b_r  <= cnt_b_nx_s;
      finish_r <= finish_nx_s;
      out_r    <= out_nx_s;
      phase_r  <= phase_nx_s;
      busy_r   <= busy_nx_s;
    end
  end

  assign out    = out_r;
  assign phase  = phase_r;
  assign busy   = busy_r;
  assign finish = finish_r;

endmodule

// File: tb/tb_count_sequencer.sv
// ----------------------------------------------------------------------------
// tb_count_sequencer
//   Directed bench for count_sequencer: a default-parameter instance (dut0) and
//   a DIV=1, LIMIT_A=3, LIMIT_B=2 instance (dut1) sharing clock and reset.
//   Inputs change 1 time unit after posedge; outputs are checked there too.
// ----------------------------------------------------------------------------
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, enable, abort;
  logic [3:0] out;
  logic       phase, busy, finish;
  logic       start1, enable1, abort1;
  logic [3:0] out1;
  logic       phase1, busy1, finish1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  count_sequencer #(.WIDTH(4), .LIMIT_A(10), .LIMIT_B(15), .DIV(2)) dut0 (
    .clk(clk), .rst(rst), .start(start), .enable(enable), .abort(abort),
    .out(out), .phase(phase), .busy(busy), .finish(finish)
  );

  count_sequencer #(.WIDTH(4), .LIMIT_A(3), .LIMIT_B(2), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .enable(enable1), .abort(abort1),
    .out(out1), .phase(phase1), .busy(busy1), .finish(finish1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int o, input int ph, input int bz, input int fn);
    check({tag, "_out"},    32'(out),    o);
    check({tag, "_phase"},  32'(phase),  ph);
    check({tag, "_busy"},   32'(busy),   bz);
    check({tag, "_finish"}, 32'(finish), fn);
  endtask

  // full default run from IDLE/DONE; optional enable drop of 'pause' cycles at cnt_a=4
  task automatic run_default(input int pause);
    start  = 1'b1;
    enable = 1'b1;
    step();
    start  = 1'b0;
    for (int v = 0; v <= 10; v++) begin
      check_outs("phA", v, 0, 1, 0);
      if (v == 4 && pause > 0) begin
        enable = 1'b0;
        for (int p = 0; p < pause; p++) begin
          step();
          check_outs("phA_hold", 4, 0, 1, 0);
        end
        enable = 1'b1;
      end
      step();
    end
    for (int b = 0; b <= 15; b++) begin
      for (int h = 0; h < 2; h++) begin
        check_outs("phB", b, 1, 1, 0);
        step();
      end
    end
    check_outs("done", 0, 0, 0, 1);
  endtask

  int ea[7] = '{0, 1, 2, 3, 0, 1, 2};
  int ep[7] = '{0, 0, 0, 0, 1, 1, 1};

  initial begin
    rst = 1'b0;
    start = 1'b0; enable = 1'b0; abort = 1'b0;
    start1 = 1'b0; enable1 = 1'b0; abort1 = 1'b0;
    #1;
    check_outs("reset", 0, 0, 0, 0);
    check("reset_out1", 32'(out1), 0);
    check("reset_fin1", 32'(finish1), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    check_outs("idle", 0, 0, 0, 0);

    // 1: nominal run, finish at cycle 44
    run_default(0);
    step();
    check_outs("done_hold", 0, 0, 0, 1);

    // 2: restart from DONE with a 5-cycle enable drop
    run_default(5);

    // 3: abort at cnt_b=7, then a clean full run
    start = 1'b1; enable = 1'b1;
    step();
    start = 1'b0;
    repeat (25) step();
    check_outs("pre_abort", 7, 1, 1, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_outs("abort", 0, 0, 0, 0);
    repeat (3) step();
    check_outs("abort_idle", 0, 0, 0, 0);
    run_default(0);

    // 4: async reset in phase A at cnt_a=9
    start = 1'b1; enable = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    check_outs("pre_rst", 9, 0, 1, 0);
    #2;
    rst = 1'b0;
    #1;
    check_outs("async_rst", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    check_outs("post_rst", 0, 0, 0, 0);
    enable = 1'b0;

    // 5: start+abort in IDLE stays IDLE; start while busy ignored
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check_outs("st_ab", 0, 0, 0, 0);
    step();
    check_outs("st_ab2", 0, 0, 0, 0);
    start = 1'b1; enable = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check_outs("busy3", 3, 0, 1, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check_outs("busy_start", 4, 0, 1, 0);
    step();
    check_outs("busy_cont", 5, 0, 1, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    enable = 1'b0;
    check_outs("abort2", 0, 0, 0, 0);

    // 6: DIV=1, LIMIT_A=3, LIMIT_B=2 instance
    start1 = 1'b1; enable1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check("d1_out",   32'(out1),    ea[k]);
      check("d1_phase", 32'(phase1),  ep[k]);
      check("d1_busy",  32'(busy1),   1);
      check("d1_fin",   32'(finish1), 0);
      step();
    end
    check("d1_done_fin",  32'(finish1), 1);
    check("d1_done_busy", 32'(busy1),   0);
    check("d1_done_out",  32'(out1),    0);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("d1_restart_fin",  32'(finish1), 0);
    check("d1_restart_busy", 32'(busy1),   1);
    check("d1_restart_out",  32'(out1),    0);
    abort1 = 1'b1;
    step();
    abort1 = 1'b0;
    check("d1_abort_busy", 32'(busy1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
